// File: rtl/fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : fetch_ctrl                                               |
// | Description: Instruction fetch sequencer with fixed-latency memory,   |
// |              valid/ready hand-off to decode and redirect priority.    |
// |              Optional macro MISALIGN_TRAP_EN enables misaligned-      |
// |              redirect trapping into a HALT state.                     |
// | Revision   : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MEM_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ProgramCounter,
  input  logic [31:0] InstructionRegister,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        misalign_fault
);

  localparam logic [1:0] c_FETCH = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;
  localparam logic [1:0] c_HALT  = 2'd3;
  localparam logic [3:0] c_LAST  = 4'(MEM_LATENCY - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_pc;
  logic [31:0] r_instOut;
  logic [31:0] r_instPc;
  logic        r_valid;
  logic        r_fault;

  logic [31:0] w_redirPc;
  logic        w_misalign;

`ifdef MISALIGN_TRAP_EN
  assign w_redirPc  = redirect_pc;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  // Low address bits are dropped, so a misaligned target fetches its word.
  logic w_unusedLowBits;
  assign w_unusedLowBits = ^redirect_pc[1:0];
  assign w_redirPc       = {redirect_pc[31:2], 2'b00};
  assign w_misalign      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_FETCH;
      r_count   <= 4'd0;
      r_pc      <= RESET_VECTOR;
      r_instOut <= 32'd0;
      r_instPc  <= 32'd0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle accept.
      r_count <= 4'd0;
      r_valid <= 1'b0;
      if (w_misalign) begin
        r_fault <= 1'b1;
        r_state <= c_HALT;
      end else begin
        r_fault <= 1'b0;
        r_pc    <= w_redirPc;
        r_state <= c_FETCH;
      end
    end else begin
      case (r_state)
        c_FETCH: begin
          r_count <= 4'd0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          r_count <= r_count + 4'd1;
          if (r_count == c_LAST) begin
            r_instOut <= InstructionRegister;
            r_instPc  <= r_pc;
            r_valid   <= 1'b1;
            r_state   <= c_HOLD;
          end
        end
        c_HOLD: begin
          if (inst_ready) begin
            r_valid <= 1'b0;
            r_pc    <= r_pc + 32'd4;
            r_state <= c_FETCH;
          end
        end
        c_HALT: begin
          r_valid <= 1'b0;
        end
        default: r_state <= c_FETCH;
      endcase
    end
  end

  assign ProgramCounter = r_pc;
  assign inst_valid     = r_valid;
  assign inst_out       = r_instOut;
  assign inst_pc        = r_instPc;
  assign misalign_fault = r_fault;

endmodule
`default_nettype wire
